// File: rtl/apb_buf_pkg.sv
// -----------------------------------------------------------------------------
// apb_buf_pkg
// Shared types and helpers for the APB request buffer:
//   apb_req_t  - one queued request (address, write data, direction, select)
//   state_t    - issue FSM states
//   SEL_NONE   - select value of an unmapped address
//   ERR_OK / ERR_DECODE - response error codes
//   decode_sel - 2-bit address region to one-hot slave select
// -----------------------------------------------------------------------------
package apb_buf_pkg;

    localparam logic [2:0] SEL_NONE   = 3'b000;
    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_DECODE = 2'b01;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [2:0]  sel;
    } apb_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_LOCAL
    } state_t;

    // Region 3 has no slave behind it.
    function automatic logic [2:0] decode_sel(input logic [1:0] region);
        logic [2:0] sel;
        case (region)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// -----------------------------------------------------------------------------
// apb_req_fifo
// Synchronous FIFO of apb_req_t entries, DEPTH a power of two.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset (pointers only)
//   i_push, i_din   write an entry (ignored while full)
//   i_pop           drop the head entry (ignored while empty)
//   o_head          current head entry
//   o_full, o_empty occupancy flags from the current pointers
//   o_full_nxt      full flag as it will be after this edge's push/pop
// -----------------------------------------------------------------------------
module apb_req_fifo
    import apb_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_push,
    input  apb_req_t i_din,
    input  logic     i_pop,
    output apb_req_t o_head,
    output logic     o_full,
    output logic     o_empty,
    output logic     o_full_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] w_wptr_nxt;
    logic [AW:0] w_rptr_nxt;
    logic        w_do_push;
    logic        w_do_pop;
    apb_req_t    r_mem [DEPTH];

    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign w_wptr_nxt = w_do_push ? (r_wptr + PTR_ONE) : r_wptr;
    assign w_rptr_nxt = w_do_pop  ? (r_rptr + PTR_ONE) : r_rptr;

    assign o_full_nxt = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                        (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);

    assign o_head = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/apb_req_buffer.sv
// -----------------------------------------------------------------------------
// apb_req_buffer
// In-order request queue and address decoder in front of the APB controller.
// Requests are decoded to a one-hot slave select on entry, queued, issued one
// at a time, and each completion is returned as a registered response pulse.
//
// Build option: APB_BUF_DECERR_EN
//   defined   - an unmapped head is completed locally with ERR_DECODE
//   undefined - an unmapped head is forwarded with p_req_sel = 3'b000
//
// Ports:
//   Pclk, Presetn          clock, synchronous active-low reset
//   req_valid/req_ready    bridge request handshake (ready = registered !full)
//   req_addr/wdata/write   bridge request fields
//   p_req_valid/accept     head offer to the controller and its acceptance
//   p_req_addr/wdata/write/sel  head fields, held from ISSUE until response
//   p_resp_valid/rdata/err controller completion (honoured only in WAIT)
//   rsp_valid/rdata/err    one-cycle response to the bridge
// -----------------------------------------------------------------------------
module apb_req_buffer
    import apb_buf_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SEL_LSB = 12
) (
    input  logic        Pclk,
    input  logic        Presetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    output logic        p_req_valid,
    input  logic        p_req_accept,
    output logic [31:0] p_req_addr,
    output logic [31:0] p_req_wdata,
    output logic        p_req_write,
    output logic [2:0]  p_req_sel,
    input  logic        p_resp_valid,
    input  logic [31:0] p_resp_rdata,
    input  logic [1:0]  p_resp_err,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);

    state_t      r_state;
    logic        r_req_ready;
    logic        r_p_req_valid;
    logic [31:0] r_p_req_addr;
    logic [31:0] r_p_req_wdata;
    logic        r_p_req_write;
    logic [2:0]  r_p_req_sel;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_err;

    apb_req_t    w_din;
    apb_req_t    w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_full_nxt;
    logic        w_push;
    logic        w_pop;
    logic        w_go_issue;
    logic        w_go_local;

    assign w_push = req_valid && r_req_ready && !w_full;

    // The head is only released once its completion has been seen.
    assign w_pop = ((r_state == ST_WAIT) && p_resp_valid) || (r_state == ST_LOCAL);

    always_comb begin
        w_din       = '0;
        w_din.addr  = req_addr;
        w_din.wdata = req_wdata;
        w_din.write = req_write;
        w_din.sel   = decode_sel(req_addr[SEL_LSB+1:SEL_LSB]);
    end

    always_comb begin
`ifdef APB_BUF_DECERR_EN
        w_go_local = !w_empty && (w_head.sel == SEL_NONE);
        w_go_issue = !w_empty && (w_head.sel != SEL_NONE);
`else
        w_go_local = 1'b0;
        w_go_issue = !w_empty;
`endif
    end

    apb_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (Pclk),
        .i_rst_n    (Presetn),
        .i_push     (w_push),
        .i_din      (w_din),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_full_nxt (w_full_nxt)
    );

    // Ready is the post-edge !full; a pop while full frees a slot only for
    // the following cycle.
    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            r_req_ready <= 1'b0;
        end else begin
            r_req_ready <= !w_full_nxt;
        end
    end

    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            r_state       <= ST_IDLE;
            r_p_req_valid <= 1'b0;
            r_p_req_addr  <= '0;
            r_p_req_wdata <= '0;
            r_p_req_write <= 1'b0;
            r_p_req_sel   <= SEL_NONE;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= ERR_OK;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go_local) begin
                        r_state <= ST_LOCAL;
                    end else if (w_go_issue) begin
                        r_state       <= ST_ISSUE;
                        r_p_req_valid <= 1'b1;
                        r_p_req_addr  <= w_head.addr;
                        r_p_req_wdata <= w_head.wdata;
                        r_p_req_write <= w_head.write;
                        r_p_req_sel   <= w_head.sel;
                    end
                end
                ST_ISSUE: begin
                    if (p_req_accept) begin
                        r_state       <= ST_WAIT;
                        r_p_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (p_resp_valid) begin
                        r_state       <= ST_IDLE;
                        r_p_req_addr  <= '0;
                        r_p_req_wdata <= '0;
                        r_p_req_write <= 1'b0;
                        r_p_req_sel   <= SEL_NONE;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_p_req_write ? 32'd0 : p_resp_rdata;
                        r_rsp_err     <= p_resp_err;
                    end
                end
                ST_LOCAL: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= ERR_DECODE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign p_req_valid = r_p_req_valid;
    assign p_req_addr  = r_p_req_addr;
    assign p_req_wdata = r_p_req_wdata;
    assign p_req_write = r_p_req_write;
    assign p_req_sel   = r_p_req_sel;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_apb_req_buffer.sv
// -----------------------------------------------------------------------------
// tb_apb_req_buffer
// Self-checking bench: the bench plays the bridge (request producer) and the
// APB controller, and keeps a queue of taken requests as the reference model.
// -----------------------------------------------------------------------------
module tb_apb_req_buffer;

    logic        Pclk = 1'b0;
    logic        Presetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic        p_req_valid;
    logic        p_req_accept;
    logic [31:0] p_req_addr;
    logic [31:0] p_req_wdata;
    logic        p_req_write;
    logic [2:0]  p_req_sel;
    logic        p_resp_valid;
    logic [31:0] p_resp_rdata;
    logic [1:0]  p_resp_err;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    apb_req_buffer #(.DEPTH(4), .SEL_LSB(12)) dut (
        .Pclk         (Pclk),
        .Presetn      (Presetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_write    (req_write),
        .p_req_valid  (p_req_valid),
        .p_req_accept (p_req_accept),
        .p_req_addr   (p_req_addr),
        .p_req_wdata  (p_req_wdata),
        .p_req_write  (p_req_write),
        .p_req_sel    (p_req_sel),
        .p_resp_valid (p_resp_valid),
        .p_resp_rdata (p_resp_rdata),
        .p_resp_err   (p_resp_err),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 Pclk = ~Pclk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } treq_t;

    treq_t pq[$];   // waiting to be offered
    treq_t mq[$];   // taken by the DUT, response still owed

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int ctl_phase = 0;
    bit ctl_stall = 0;
    bit ctl_served = 0;
    bit spur = 0;
    bit gap_en = 0;
    bit force_en = 0;
    logic [31:0] force_rdata = '0;
    logic [1:0]  force_err = '0;
    logic [31:0] ctl_rdata;
    logic [1:0]  ctl_err;
    treq_t       cur;
    logic [2:0]  cur_sel;

    int push_cnt = 0, issue_cnt = 0, rsp_count = 0;
    int last_push_cyc = 0, last_issue_cyc = 0, last_rsp_cyc = 0;
    logic [2:0]  last_issue_sel;
    logic [31:0] last_rsp_rdata;
    logic [1:0]  last_rsp_err;

    // Region is addr[13:12]; regions 0..2 select one slave each, 3 none.
    function automatic logic [2:0] model_sel(input logic [31:0] a);
        int region;
        region = (a >> 12) % 4;
        return (region == 3) ? 3'b000 : 3'(1 << region);
    endfunction

    function automatic bit model_local(input logic [31:0] a);
`ifdef APB_BUF_DECERR_EN
        return model_sel(a) == 3'b000;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        treq_t h;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
        bit ok;
        @(negedge Pclk);
        cyc++;
        // bridge-side response check
        if (rsp_valid) begin
            total++;
            rsp_count++;
            last_rsp_cyc   = cyc;
            last_rsp_rdata = rsp_rdata;
            last_rsp_err   = rsp_err;
            if (mq.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
                h = mq.pop_front();
                ok = 1'b1;
                if (model_local(h.addr)) begin
                    exp_rd = 32'd0; exp_err = 2'b01;
                end else begin
                    exp_rd = h.write ? 32'd0 : ctl_rdata;
                    exp_err = ctl_err;
                    ok = ctl_served;
                    ctl_served = 1'b0;
                end
                if (!ok || rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
                    bad++;
                    $display("FAIL rsp_data addr=%h: got rdata=%h err=%b served=%0d, required rdata=%h err=%b", h.addr, rsp_rdata, rsp_err, ok, exp_rd, exp_err);
                end
            end
        end
        // controller
        case (ctl_phase)
            0: begin
                p_resp_valid = spur;
                p_req_accept = 1'b0;
                if (p_req_valid) begin
                    total++;
                    issue_cnt++;
                    last_issue_cyc = cyc;
                    last_issue_sel = p_req_sel;
                    if (mq.size() == 0 || model_local(mq[0].addr)) begin
                        bad++;
                        $display("FAIL issue_unexpected: got p_req_valid=1 addr=%h, required no issue", p_req_addr);
                        cur = '{p_req_addr, p_req_wdata, p_req_write};
                        cur_sel = p_req_sel;
                    end else begin
                        cur = mq[0];
                        cur_sel = model_sel(cur.addr);
                        if (p_req_addr !== cur.addr || p_req_wdata !== cur.wdata ||
                            p_req_write !== cur.write || p_req_sel !== cur_sel) begin
                            bad++;
                            $display("FAIL issue_fields: got %h/%h/%b/%b, required %h/%h/%b/%b", p_req_addr, p_req_wdata, p_req_write, p_req_sel, cur.addr, cur.wdata, cur.write, cur_sel);
                        end
                    end
                    p_req_accept = 1'b1;
                    ctl_rdata = force_en ? force_rdata : $urandom;
                    ctl_err   = force_en ? force_err : 2'($urandom_range(0, 3));
                    ctl_phase = 1;
                end
            end
            1, 2: begin
                p_req_accept = 1'b0;
                total++;
                if (p_req_valid !== 1'b0 || p_req_addr !== cur.addr || p_req_wdata !== cur.wdata ||
                    p_req_write !== cur.write || p_req_sel !== cur_sel) begin
                    bad++;
                    $display("FAIL wait_hold: got valid=%b %h/%h/%b/%b, required valid=0 %h/%h/%b/%b", p_req_valid, p_req_addr, p_req_wdata, p_req_write, p_req_sel, cur.addr, cur.wdata, cur.write, cur_sel);
                end
                if (ctl_phase == 1) begin
                    ctl_phase = 2;
                end else if (!ctl_stall) begin
                    p_resp_valid = 1'b1;
                    p_resp_rdata = ctl_rdata;
                    p_resp_err   = ctl_err;
                    ctl_served   = 1'b1;
                    ctl_phase    = 3;
                end
            end
            default: begin
                p_resp_valid = 1'b0;
                p_resp_rdata = $urandom;
                p_resp_err   = 2'($urandom_range(0, 3));
                ctl_phase    = 0;
            end
        endcase
        // producer
        if (pq.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            req_valid = 1'b1;
            req_addr  = pq[0].addr;
            req_wdata = pq[0].wdata;
            req_write = pq[0].write;
            if (req_ready) begin
                mq.push_back(pq.pop_front());
                push_cnt++;
                last_push_cyc = cyc;
            end
        end else begin
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_write = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pq.size() != 0 || mq.size() != 0 || ctl_phase != 0) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d/%0d after %0d cycles, required 0", pq.size(), mq.size(), n);
            pq.delete();
        end
    endtask

    task automatic test_reset();
        Presetn = 1'b0;
        req_valid = 0; req_addr = 0; req_wdata = 0; req_write = 0;
        p_req_accept = 0; p_resp_valid = 0; p_resp_rdata = 0; p_resp_err = 0;
        repeat (3) tick();
        total++;
        if ({req_ready, p_req_valid, p_req_addr, p_req_wdata, p_req_write, p_req_sel, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            bad++;
            $display("FAIL reset_state: got ready=%b pv=%b addr=%h wd=%h w=%b sel=%b rv=%b rd=%h err=%b, required all 0", req_ready, p_req_valid, p_req_addr, p_req_wdata, p_req_write, p_req_sel, rsp_valid, rsp_rdata, rsp_err);
        end
        Presetn = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_single_write();
        int t0;
        force_en = 1; force_rdata = 32'h1234_5678; force_err = 2'b00;
        pq.push_back('{32'h0000_1004, 32'hA5A5_0001, 1'b1});
        tick();
        t0 = last_push_cyc;
        wait_idle(50);
        total++;
        if (last_issue_cyc !== t0 + 2 || last_issue_sel !== 3'b010) begin
            bad++;
            $display("FAIL write_issue: got cycle=%0d sel=%b, required cycle=%0d sel=010", last_issue_cyc, last_issue_sel, t0 + 2);
        end
        total++;
        if (last_rsp_cyc !== t0 + 5 || last_rsp_rdata !== 32'd0 || last_rsp_err !== 2'b00) begin
            bad++;
            $display("FAIL write_rsp: got cycle=%0d rdata=%h err=%b, required cycle=%0d rdata=0 err=00", last_rsp_cyc, last_rsp_rdata, last_rsp_err, t0 + 5);
        end
        force_en = 0;
    endtask

    task automatic test_single_read();
        force_en = 1; force_rdata = 32'hDEAD_BEEF; force_err = 2'b00;
        pq.push_back('{32'h0000_2010, 32'h0, 1'b0});
        wait_idle(50);
        total++;
        if (last_issue_sel !== 3'b100 || last_rsp_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL read_rsp: got sel=%b rdata=%h, required sel=100 rdata=deadbeef", last_issue_sel, last_rsp_rdata);
        end
        force_en = 0;
    endtask

    task automatic test_fill();
        int base = rsp_count;
        int p0 = push_cnt;
        int n = 0;
        for (int i = 0; i < 5; i++)
            pq.push_back('{32'($urandom_range(0, 2)) << 12 | 32'(i * 4), $urandom, 1'($urandom_range(0, 1))});
        while (push_cnt - p0 < 4 && n < 20) begin tick(); n++; end
        tick();
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_ready: got req_ready=%b after 4th push, required 0", req_ready);
        end
        wait_idle(200);
        total++;
        if (rsp_count - base !== 5) begin
            bad++;
            $display("FAIL fill_count: got %0d responses, required 5", rsp_count - base);
        end
    endtask

    task automatic test_unmapped();
        int t0;
        int i0 = issue_cnt;
        pq.push_back('{32'h0000_3000, 32'h0BAD_0BAD, 1'b1});
        tick();
        t0 = last_push_cyc;
        wait_idle(50);
`ifdef APB_BUF_DECERR_EN
        total++;
        if (issue_cnt !== i0 || last_rsp_cyc !== t0 + 3 || last_rsp_err !== 2'b01 || last_rsp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL unmapped_local: got issues=%0d cycle=%0d err=%b rdata=%h, required issues=0 cycle=%0d err=01 rdata=0", issue_cnt - i0, last_rsp_cyc, last_rsp_err, last_rsp_rdata, t0 + 3);
        end
`else
        total++;
        if (issue_cnt !== i0 + 1 || last_issue_sel !== 3'b000 || last_issue_cyc !== t0 + 2) begin
            bad++;
            $display("FAIL unmapped_fwd: got issues=%0d sel=%b cycle=%0d, required issues=1 sel=000 cycle=%0d", issue_cnt - i0, last_issue_sel, last_issue_cyc, t0 + 2);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int base_rsp, base_iss;
        ctl_stall = 1;
        for (int i = 0; i < 4; i++)
            pq.push_back('{32'($urandom_range(0, 2)) << 12, $urandom, 1'b0});
        while (!(pq.size() == 0 && ctl_phase == 2) && n < 50) begin tick(); n++; end
        tick();
        total++;
        if (req_ready !== 1'b0 || ctl_phase !== 2) begin
            bad++;
            $display("FAIL midrst_setup: got ready=%b phase=%0d, required ready=0 phase=2", req_ready, ctl_phase);
        end
        Presetn = 1'b0;
        ctl_phase = 0; ctl_stall = 0; ctl_served = 0;
        p_req_accept = 0; p_resp_valid = 0; req_valid = 0;
        mq.delete();
        base_rsp = rsp_count;
        base_iss = issue_cnt;
        tick();
        total++;
        if (p_req_valid !== 1'b0 || p_req_addr !== 32'd0 || p_req_sel !== 3'b000 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_flush: got pv=%b addr=%h sel=%b ready=%b, required all 0", p_req_valid, p_req_addr, p_req_sel, req_ready);
        end
        Presetn = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready: got %b, required 1", req_ready);
        end
        repeat (20) tick();
        total++;
        if (issue_cnt !== base_iss || rsp_count !== base_rsp) begin
            bad++;
            $display("FAIL midrst_quiet: got issues=%0d rsps=%0d, required 0 and 0", issue_cnt - base_iss, rsp_count - base_rsp);
        end
    endtask

    task automatic test_spurious();
        int base = rsp_count;
        int t0;
        spur = 1; tick(); spur = 0;
        repeat (3) tick();
        total++;
        if (rsp_count !== base) begin
            bad++;
            $display("FAIL spur_idle: got %0d responses, required 0", rsp_count - base);
        end
        pq.push_back('{32'h0000_0020, 32'h0, 1'b0});
        tick();
        t0 = last_push_cyc;
        spur = 1; tick(); spur = 0;
        wait_idle(50);
        total++;
        if (last_issue_cyc !== t0 + 2 || rsp_count !== base + 1) begin
            bad++;
            $display("FAIL spur_nopop: got issue cycle=%0d rsps=%0d, required cycle=%0d rsps=1", last_issue_cyc, rsp_count - base, t0 + 2);
        end
    endtask

    task automatic test_random();
        int base = rsp_count;
        gap_en = 1;
        for (int i = 0; i < 40; i++)
            pq.push_back('{$urandom, $urandom, 1'($urandom_range(0, 1))});
        wait_idle(2000);
        gap_en = 0;
        total++;
        if (rsp_count - base !== 40) begin
            bad++;
            $display("FAIL random_count: got %0d responses, required 40", rsp_count - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_fill();
        test_unmapped();
        test_spurious();
        test_reset_mid();
        test_random();
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
